// File: rtl/blit_pkg.sv
// Shared types and defaults for the sprite blitter.
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'h0,
    SCAN  = 2'h1,
    DRAIN = 2'h2,
    DONE  = 2'h3
  } blitState_t;

  localparam int unsigned DEF_COLOUR_WIDTH = 8;
  localparam logic [DEF_COLOUR_WIDTH-1:0] DEF_KEY_COLOUR = 8'h00;

  // Counter width for a dimension of n pixels (at least one bit).
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster col/row counters and flipped ROM address generation.
module sprite_addr_gen
  import blit_pkg::*;
#(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int COL_W      = cntWidth(SPR_W),
  parameter int ROW_W      = cntWidth(SPR_H)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  advance,
  input  logic                  flipX,
  input  logic                  flipY,
  output logic [COL_W-1:0]      col,
  output logic [ROW_W-1:0]      row,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] romAddr
);

  logic             colLast;
  logic             rowLast;
  logic [COL_W-1:0] ac;
  logic [ROW_W-1:0] ar;

  assign colLast = (col == COL_W'(SPR_W - 1));
  assign rowLast = (row == ROW_W'(SPR_H - 1));
  assign last    = colLast & rowLast;

  // Raster counters: column first, wrapping into the next row.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (colLast) begin
        col <= '0;
        row <= rowLast ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Mirror the sprite-space coordinates and form the linear ROM address.
  always_comb begin
    ac      = flipX ? COL_W'(SPR_W - 1) - col : col;
    ar      = flipY ? ROW_W'(SPR_H - 1) - row : row;
    romAddr = ADDR_WIDTH'(ar) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(ac);
  end

endmodule

// File: rtl/sprite_blit.sv
// Sprite blitter: streams a ROM sprite to the VGA write port with
// flip, colour-key transparency and screen-edge clipping.
module sprite_blit
  import blit_pkg::*;
#(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int X_MAX        = 160,
  parameter int Y_MAX        = 120,
  parameter int SPR_W        = 16,
  parameter int SPR_H        = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
  parameter logic [COLOUR_WIDTH-1:0] KEY_COLOUR = COLOUR_WIDTH'(DEF_KEY_COLOUR)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [X_WIDTH-1:0]      xInit,
  input  logic [Y_WIDTH-1:0]      yInit,
  input  logic                    flipX,
  input  logic                    flipY,
  input  logic                    keyEn,
  output logic [ADDR_WIDTH-1:0]   romAddr,
  input  logic [COLOUR_WIDTH-1:0] romData,
  output logic [X_WIDTH-1:0]      xOut,
  output logic [Y_WIDTH-1:0]      yOut,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    writeEn,
  output logic                    busy,
  output logic                    done
);

  localparam int COL_W = cntWidth(SPR_W);
  localparam int ROW_W = cntWidth(SPR_H);
  localparam int XW1   = X_WIDTH + 1;
  localparam int YW1   = Y_WIDTH + 1;

  blitState_t         state;
  logic [X_WIDTH-1:0] xLat;
  logic [Y_WIDTH-1:0] yLat;
  logic               flipXLat;
  logic               flipYLat;
  logic               keyLat;
  logic               pv;
  logic [XW1-1:0]     px;
  logic [YW1-1:0]     py;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last;
  logic [XW1-1:0]     sx;
  logic [YW1-1:0]     sy;
  logic               accept;
  logic               keyed;

  assign accept = (state == IDLE) && start;

  sprite_addr_gen #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) uAddrGen (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .advance (state == SCAN),
    .flipX   (flipXLat),
    .flipY   (flipYLat),
    .col     (col),
    .row     (row),
    .last    (last),
    .romAddr (romAddr)
  );

  // One extra bit so coordinates past the screen edge clip instead of wrapping.
  assign sx = {1'b0, xLat} + XW1'(col);
  assign sy = {1'b0, yLat} + YW1'(row);

  // Control FSM, input latches and the pixel pipe stage aligned with romData.
  // busy/done are registered alongside the state rather than decoded from it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pv       <= 1'b0;
      px       <= '0;
      py       <= '0;
      xLat     <= '0;
      yLat     <= '0;
      flipXLat <= 1'b0;
      flipYLat <= 1'b0;
      keyLat   <= 1'b0;
    end else begin
      pv <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xLat     <= xInit;
            yLat     <= yInit;
            flipXLat <= flipX;
            flipYLat <= flipY;
            keyLat   <= keyEn;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          pv <= 1'b1;
          px <= sx;
          py <= sy;
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel write qualification: clip to the screen and drop keyed colours.
  always_comb begin
    keyed   = keyLat && (romData == KEY_COLOUR);
    writeEn = pv && (px < XW1'(X_MAX)) && (py < YW1'(Y_MAX)) && !keyed;
    colour  = pv ? romData : '0;
    xOut    = px[X_WIDTH-1:0];
    yOut    = py[Y_WIDTH-1:0];
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Testbench for sprite_blit using a 4x4 sprite and a behavioural ROM/model.
module tb_sprite_blit;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int N  = SW * SH;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] xInit;
  logic [6:0] yInit;
  logic       flipX;
  logic       flipY;
  logic       keyEn;
  logic [7:0] romAddr;
  logic [7:0] romData;
  logic [7:0] xOut;
  logic [6:0] yOut;
  logic [7:0] colour;
  logic       writeEn;
  logic       busy;
  logic       done;

  logic [7:0] rom [0:255];

  int nChecks = 0;
  int nPass   = 0;

  int obsX[$], obsY[$], obsC[$];
  int expX[$], expY[$], expC[$];
  int doneCycle;

  sprite_blit #(
    .SPR_W (SW),
    .SPR_H (SH)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .xInit   (xInit),
    .yInit   (yInit),
    .flipX   (flipX),
    .flipY   (flipY),
    .keyEn   (keyEn),
    .romAddr (romAddr),
    .romData (romData),
    .xOut    (xOut),
    .yOut    (yOut),
    .colour  (colour),
    .writeEn (writeEn),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) romData <= rom[romAddr];

  function automatic void fillRamp();
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
  endfunction

  // Reference: every sprite pixel in raster order, mirrored, clipped and keyed.
  function automatic void buildExpected(input int x, input int y, input bit fx,
                                        input bit fy, input bit ke);
    int ar, ac, cv;
    expX.delete(); expY.delete(); expC.delete();
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        ar = fy ? SH - 1 - r : r;
        ac = fx ? SW - 1 - c : c;
        cv = int'(rom[ar * SW + ac]);
        if ((x + c) < 160 && (y + r) < 120 && !(ke && cv == 0)) begin
          expX.push_back(x + c);
          expY.push_back(y + r);
          expC.push_back(cv);
        end
      end
    end
  endfunction

  // Issue one draw and record observed writes and the done latency.
  task automatic runDraw(input int x, input int y, input bit fx, input bit fy,
                         input bit ke, input bit holdStart);
    obsX.delete(); obsY.delete(); obsC.delete();
    doneCycle = -1;
    @(negedge clk);
    xInit = 8'(x); yInit = 7'(y); flipX = fx; flipY = fy; keyEn = ke;
    start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      xInit = 8'($urandom); yInit = 7'($urandom);
      flipX = 1'($urandom); flipY = 1'($urandom); keyEn = 1'($urandom);
      if (writeEn) begin
        obsX.push_back(int'(xOut));
        obsY.push_back(int'(yOut));
        obsC.push_back(int'(colour));
      end
      if (done) begin
        doneCycle = k;
        break;
      end
    end
  endtask

  task automatic finishDraw();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0;
    xInit = '0; yInit = '0; flipX = 0; flipY = 0; keyEn = 0;
    fillRamp();
    repeat (3) @(negedge clk);
    nChecks++;
    if ({writeEn, busy, done} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {writeEn, busy, done});
    else nPass++;
    nChecks++;
    if ({xOut, yOut, colour, romAddr} !== '0)
      $display("FAIL reset_values got x=%0d y=%0d c=%0d a=%0d want 0", xOut, yOut, colour, romAddr);
    else nPass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain();
    fillRamp();
    buildExpected(10, 20, 0, 0, 0);
    runDraw(10, 20, 0, 0, 0, 0);
    nChecks++;
    if (doneCycle !== N + 2) $display("FAIL plain_latency got %0d want %0d", doneCycle, N + 2);
    else nPass++;
    nChecks++;
    if (obsX.size() !== 16) $display("FAIL plain_count got %0d want 16", obsX.size());
    else nPass++;
    if (obsX.size() == 16) begin
      nChecks++;
      if (obsX[0] !== 10 || obsY[0] !== 20 || obsC[0] !== 0)
        $display("FAIL plain_first got (%0d,%0d,%0d) want (10,20,0)", obsX[0], obsY[0], obsC[0]);
      else nPass++;
      nChecks++;
      if (obsX[15] !== 13 || obsY[15] !== 23 || obsC[15] !== 15)
        $display("FAIL plain_last got (%0d,%0d,%0d) want (13,23,15)", obsX[15], obsY[15], obsC[15]);
      else nPass++;
      for (int i = 0; i < 16; i++) begin
        nChecks++;
        if (obsX[i] !== expX[i] || obsY[i] !== expY[i] || obsC[i] !== expC[i])
          $display("FAIL plain_px%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                   obsX[i], obsY[i], obsC[i], expX[i], expY[i], expC[i]);
        else nPass++;
      end
    end
    finishDraw();
  endtask

  task automatic test_flip();
    fillRamp();
    runDraw(10, 20, 1, 0, 0, 0);
    nChecks++;
    if (obsX.size() < 4 || obsX[0] !== 10 || obsY[0] !== 20 || obsC[0] !== 3)
      $display("FAIL flipx_first got n=%0d want (10,20,3)", obsX.size());
    else nPass++;
    nChecks++;
    if (obsX.size() < 4 || obsX[3] !== 13 || obsY[3] !== 20 || obsC[3] !== 0)
      $display("FAIL flipx_fourth got n=%0d want (13,20,0)", obsX.size());
    else nPass++;
    finishDraw();
    runDraw(10, 20, 0, 1, 0, 0);
    nChecks++;
    if (obsX.size() < 1 || obsX[0] !== 10 || obsY[0] !== 20 || obsC[0] !== 12)
      $display("FAIL flipy_first got n=%0d c=%0d want (10,20,12)", obsX.size(),
               (obsC.size() > 0) ? obsC[0] : -1);
    else nPass++;
    finishDraw();
  endtask

  task automatic test_clip();
    int wantX[4] = '{158, 159, 158, 159};
    int wantY[4] = '{118, 118, 119, 119};
    fillRamp();
    runDraw(158, 118, 0, 0, 0, 0);
    nChecks++;
    if (doneCycle !== N + 2) $display("FAIL clip_latency got %0d want %0d", doneCycle, N + 2);
    else nPass++;
    nChecks++;
    if (obsX.size() !== 4) $display("FAIL clip_count got %0d want 4", obsX.size());
    else nPass++;
    if (obsX.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (obsX[i] !== wantX[i] || obsY[i] !== wantY[i])
          $display("FAIL clip_px%0d got (%0d,%0d) want (%0d,%0d)", i, obsX[i], obsY[i],
                   wantX[i], wantY[i]);
        else nPass++;
      end
    end
    finishDraw();
  endtask

  task automatic test_key();
    bit seen;
    fillRamp();
    runDraw(10, 20, 0, 0, 1, 0);
    nChecks++;
    if (obsX.size() !== 15) $display("FAIL key_count got %0d want 15", obsX.size());
    else nPass++;
    seen = 0;
    foreach (obsX[i]) if (obsX[i] == 10 && obsY[i] == 20) seen = 1;
    nChecks++;
    if (seen !== 1'b0) $display("FAIL key_origin got write at (10,20) want none");
    else nPass++;
    nChecks++;
    if (doneCycle !== N + 2) $display("FAIL key_latency got %0d want %0d", doneCycle, N + 2);
    else nPass++;
    finishDraw();
  endtask

  task automatic test_random();
    int x, y;
    bit fx, fy, ke;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 256; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      x  = (t % 3 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
      y  = (t % 3 == 1) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
      fx = 1'($urandom); fy = 1'($urandom); ke = 1'($urandom);
      buildExpected(x, y, fx, fy, ke);
      runDraw(x, y, fx, fy, ke, 0);
      nChecks++;
      if (doneCycle !== N + 2) $display("FAIL rand%0d_latency got %0d want %0d", t, doneCycle, N + 2);
      else nPass++;
      nChecks++;
      if (obsX.size() !== expX.size())
        $display("FAIL rand%0d_count got %0d want %0d", t, obsX.size(), expX.size());
      else begin
        nPass++;
        for (int i = 0; i < expX.size(); i++) begin
          nChecks++;
          if (obsX[i] !== (expX[i] & 8'hff) || obsY[i] !== (expY[i] & 7'h7f) || obsC[i] !== expC[i])
            $display("FAIL rand%0d_px%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", t, i,
                     obsX[i], obsY[i], obsC[i], expX[i], expY[i], expC[i]);
          else nPass++;
        end
      end
      finishDraw();
    end
  endtask

  task automatic test_reset_midscan();
    int writes = 0;
    bit reached = 0;
    fillRamp();
    @(negedge clk);
    xInit = 8'd10; yInit = 7'd20; flipX = 0; flipY = 0; keyEn = 0;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (writeEn) writes++;
      if (writes == 5) begin
        reached = 1;
        break;
      end
    end
    nChecks++;
    if (reached !== 1'b1) $display("FAIL midscan_writes got %0d want 5", writes);
    else nPass++;
    resetn = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({writeEn, busy, done} !== 3'b000)
      $display("FAIL midscan_reset got %b want 000", {writeEn, busy, done});
    else nPass++;
    resetn = 1'b1;
    @(negedge clk);
    nChecks++;
    if (done !== 1'b0) $display("FAIL midscan_nodone got %b want 0", done);
    else nPass++;
    runDraw(10, 20, 0, 0, 0, 0);
    nChecks++;
    if (doneCycle !== N + 2 || obsX.size() !== 16)
      $display("FAIL midscan_redraw got lat=%0d n=%0d want lat=%0d n=16", doneCycle, obsX.size(), N + 2);
    else nPass++;
    finishDraw();
  endtask

  task automatic test_hold_start();
    fillRamp();
    runDraw(30, 40, 0, 0, 0, 1);
    nChecks++;
    if (doneCycle !== N + 2) $display("FAIL hold_latency got %0d want %0d", doneCycle, N + 2);
    else nPass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nChecks++;
      if ({done, busy, writeEn} !== 3'b100)
        $display("FAIL hold_stay%0d got %b want 100", k, {done, busy, writeEn});
      else nPass++;
    end
    start = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({done, busy} !== 2'b00) $display("FAIL hold_release got %b want 00", {done, busy});
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({busy, writeEn} !== 2'b00) $display("FAIL hold_norestart got %b want 00", {busy, writeEn});
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_plain();
    test_flip();
    test_clip();
    test_key();
    test_random();
    test_reset_midscan();
    test_hold_start();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
